// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter shared definitions.
// Register index width, invalid tag, round-robin helper.
package cdb_arbiter_pkg;

  localparam int RD_W        = 5;
  localparam int TAG_INVALID = 0;

  function automatic int rr_next(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result sources in, common data bus out.
// master = functional units / consumers, slave = arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*RD_W-1:0]   src_rd;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [TAG_W-1:0]        wb_tag;
  logic [RD_W-1:0]         wb_rd;
  logic [DATA_W-1:0]       wb_data;

  modport master (
    output src_valid,
    output src_tag,
    output src_rd,
    output src_data,
    input  src_ready,
    input  wb_tag,
    input  wb_rd,
    input  wb_data
  );

  modport slave (
    input  src_valid,
    input  src_tag,
    input  src_rd,
    input  src_data,
    output src_ready,
    output wb_tag,
    output wb_rd,
    output wb_data
  );

endinterface

// File: rtl/cdb_fifo.sv
// Single-clock result FIFO with synchronous clear.
// Pointers wrap naturally; count is one bit wider.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(do_push)
                 - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wp] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter.
// Drains one buffered result per cycle onto a registered bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int ENT_W = TAG_W + RD_W + DATA_W;
  localparam int IDX_W = $clog2(N_SRC);

  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] empty;
  logic [ENT_W-1:0] head [N_SRC];
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  assign bus.src_ready = ~full;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [TAG_W-1:0]  tag;
    logic [ENT_W-1:0]  ent;

    assign tag = bus.src_tag[i*TAG_W +: TAG_W];
    assign ent = {tag,
                  bus.src_rd[i*RD_W +: RD_W],
                  bus.src_data[i*DATA_W +: DATA_W]};

    // Invalid-tag pushes handshake but are dropped.
    assign push[i] = bus.src_valid[i] & ~full[i]
                   & (tag != TAG_W'(TAG_INVALID));
    assign pop[i]  = gnt_any & ~flush
                   & (gnt_idx == IDX_W'(i));

    cdb_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (ent),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  always_comb begin : p_arb
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = int'(last);
    for (int k = 0; k < N_SRC; k++) begin
      idx = rr_next(idx, N_SRC);
      if (!gnt_any && !empty[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= IDX_W'(N_SRC - 1);
      bus.wb_tag  <= TAG_W'(TAG_INVALID);
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else if (flush) begin
      bus.wb_tag  <= TAG_W'(TAG_INVALID);
    end else if (gnt_any) begin
      last <= gnt_idx;
      {bus.wb_tag, bus.wb_rd, bus.wb_data}
        <= head[gnt_idx];
    end else begin
      bus.wb_tag  <= TAG_W'(TAG_INVALID);
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter that collects completed results (tag, destination register, data) from N functional units and serialises them onto the single writeback bus consumed by `reg_file` and the reservation stations. Each source has a small FIFO with a valid/ready handshake. A round-robin arbiter drains one result per cycle onto a registered bus. When no result is driven, the bus carries `TAG_INVALID`, so downstream tag comparisons never match.

## Interface
- `N_SRC`, 4: number of functional-unit result sources (2..8).
- `DATA_W`, 32: result data width (matches `COMMON_WIDTH`).
- `TAG_W`, 4: instruction tag width (matches `INST_TAG_WIDTH`). Tag value 0 is `TAG_INVALID`.
- `DEPTH`, 2: entries per source FIFO (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset rst, asynchronous, active-high.
- `flush`  in  1  synchronous mispredict/exception flush; drops all buffered and in-flight results.
- `src_valid`  in  N_SRC  per-source result valid.
- `src_ready`  out  N_SRC  per-source FIFO can accept.
- `src_tag`  in  N_SRC*TAG_W  per-source result tag, packed with source 0 at the LSBs.
- `src_rd`  in  N_SRC*5  per-source destination register index.
- `src_data`  in  N_SRC*DATA_W  per-source result data.
- `wb_tag`  out  TAG_W  writeback tag; `TAG_INVALID` when idle.
- `wb_rd`  out  5  writeback destination register.
- `wb_data`  out  DATA_W  writeback data.

## Operation
- Enqueue: source i pushes on a posedge where `src_valid[i] && src_ready[i]`.
- `src_ready[i] = (count_i < DEPTH)`. This is registered state only; a same-cycle pop does not raise ready.
- A push whose `src_tag == TAG_INVALID` completes the handshake but is discarded and not enqueued.
- Arbitration is combinational over FIFO heads with non-zero count.
  - Priority search starts at `last+1` and wraps modulo `N_SRC`.
  - `last` updates to the granted index only on a grant.
  - `last` resets to `N_SRC-1`, so source 0 has first priority after reset.
- Grant: on the posedge, the granted head is popped and loaded into the `wb_*` registers.
- No grant: `wb_tag` is loaded with `TAG_INVALID`. `wb_rd` and `wb_data` hold their previous values; they are don't-care while the tag is invalid.
- Each result appears on the bus for exactly one cycle and exactly once.
- `flush`: on the posedge, all FIFO counts and pointers are cleared and `wb_tag` becomes `TAG_INVALID`.
  - Flush beats any same-cycle push (dropped) or grant (not issued).
  - `last` is retained across flush.
- A push and pop on the same FIFO in the same cycle is legal; the count stays unchanged.
- FIFO read/write pointers are `log2(DEPTH)` bits and wrap naturally.

## Timing
- Reset values: `wb_tag=TAG_INVALID`, `wb_rd=0`, `wb_data=0`, all counts 0, `src_ready` all 1, `last=N_SRC-1`.
- Reset applies immediately, asynchronously, mid-operation; all buffered results are lost.
- Latency: a result pushed at posedge k into an empty FIFO is on `wb_*` from posedge k+1 if granted, stable for one full cycle. This is the minimum; there is no combinational path from `src_*` to `wb_*`.
- Throughput: one result per cycle aggregate. With all sources continuously backlogged, each source gets 1 grant every `N_SRC` cycles.
- The `wb_*` outputs are driven directly from flops, so `reg_file`'s combinational tag-match write sees stable values for the entire cycle.

## Structure
- `TAG_INVALID`, tag width, and data width come from `common_def.h`; the arbiter adds no new global constants.
- Sub-module `cdb_fifo`: a single-clock FIFO parameterised by width and `DEPTH`, with ports `push`, `pop`, `clear`, `full`, `empty`, and `head`. Instantiate it `N_SRC` times in a generate loop, with entry width `TAG_W+5+DATA_W`.
- Top level contains only the round-robin grant logic, the `last` register, and the `wb` output registers.

## Test plan
- Single result: after reset, source 2 pushes (tag 5, rd 3, data 0xDEADBEEF) at cycle 1. Required: `wb_tag=5`, `wb_rd=3`, `wb_data=0xDEADBEEF` during cycle 2 only; `wb_tag=0` in cycle 3.
- Fairness: all 4 sources push simultaneously (tags 1..4) after reset. Required: bus shows tags 1,2,3,4 in consecutive cycles.
- Then source 0 pushes again with tag 6 while source 3 pushes tag 7. Required: tag 6 is granted before tag 7 (`last=3` wraps to 0).
- Backpressure: source 1 pushes tags 1,2 on consecutive cycles while a higher-priority backlog holds grants. Required: `src_ready[1]=0` once count=2, the third push is not accepted, and all tags eventually appear exactly once in FIFO order.
- Flush: with 3 results buffered and a push asserted in the same cycle, assert `flush`. Required: `wb_tag=0` the next cycle, `src_ready` all 1, no buffered tag ever appears, and the dropped push never appears.
- Invalid tag plus reset: a push with tag 0 is accepted (ready stays 1) and never reaches the bus. Asserting `rst` mid-backlog immediately gives `wb_tag=0`, `wb_data=0`, and empty FIFOs.
